// File: rtl/gate_bist_2in.sv
// gate_bist_2in: built-in self-test sequencer for a single 2-input gate.
// Walks {a,b} through 00,01,10,11, waits SETTLE_CYCLES after each vector,
// samples y and compares it against the EXP_TT truth table (bit index {a,b}).
// Optional macro GATE_BIST_FIRST_FAIL_EN adds first_fail_vld/first_fail_idx,
// which record the index of the first mismatching vector of a run.
module gate_bist_2in #(
    parameter logic [3:0]  EXP_TT        = 4'b0001,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_map
`ifdef GATE_BIST_FIRST_FAIL_EN
    ,
    output logic       first_fail_vld,
    output logic [1:0] first_fail_idx
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    logic [2:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ab_q, ab_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] map_q, map_d;
    logic       mismatch;
`ifdef GATE_BIST_FIRST_FAIL_EN
    logic       ffv_q, ffv_d;
    logic [1:0] ffi_q, ffi_d;
`endif

    assign mismatch = (y_i != EXP_TT[idx_q]);

    // Next-state logic. The vector is loaded into the a/b registers on the
    // edge that enters DRIVE, so the gate inputs are already valid during
    // DRIVE and stay untouched until the edge that leaves SAMPLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        pass_d  = pass_q;
        err_d   = err_q;
        map_d   = map_q;
`ifdef GATE_BIST_FIRST_FAIL_EN
        ffv_d   = ffv_q;
        ffi_d   = ffi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 3'd0;
                    map_d   = 4'd0;
                    pass_d  = 1'b0;
                    idx_d   = 2'd0;
                    ab_d    = 2'd0;
`ifdef GATE_BIST_FIRST_FAIL_EN
                    ffv_d   = 1'b0;
                    ffi_d   = 2'd0;
`endif
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                cnt_d   = SETTLE;
                state_d = (SETTLE == 4'd0) ? S_SAMPLE : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d        = err_q + 3'd1;
                    map_d[idx_q] = 1'b1;
`ifdef GATE_BIST_FIRST_FAIL_EN
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
`endif
                end
                if (idx_q == 2'd3) begin
                    ab_d    = 2'd0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    ab_d    = idx_q + 2'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                pass_d  = (err_q == 3'd0);
                ab_d    = 2'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers, cleared immediately by the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            ab_q    <= 2'd0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            map_q   <= 4'd0;
`ifdef GATE_BIST_FIRST_FAIL_EN
            ffv_q   <= 1'b0;
            ffi_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            map_q   <= map_d;
`ifdef GATE_BIST_FIRST_FAIL_EN
            ffv_q   <= ffv_d;
            ffi_q   <= ffi_d;
`endif
        end
    end

    assign a_o      = ab_q[1];
    assign b_o      = ab_q[0];
    assign busy     = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
    assign done     = (state_q == S_DONE);
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_map = map_q;
`ifdef GATE_BIST_FIRST_FAIL_EN
    assign first_fail_vld = ffv_q;
    assign first_fail_idx = ffi_q;
`endif

endmodule
